sd_spi_target: RTL and testbench

Synthesizable SPI-mode SD card responder: the card end of the SD/SPI link that the RK8E controller drives as master. It lets the PDP8e disk path run on hardware with an FPGA block RAM standing in for the card, for loopback boards and card-less bring-up. It decodes 48-bit SD command frames and returns R1/R3/R7 responses. It serves single-block reads and writes (CMD17/CMD24) from a byte-wide external memory port.

---
 rtl/sd_spi_target_if.sv | 12 +
 rtl/sd_spi_target.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_sd_spi_target.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_target_if.sv
// sd_spi_target_if: SPI-mode SD link between a host (master) and the card (slave).
// Signals: sdCS (active-low select), sdSCLK (mode-0 clock), sdMOSI (host->card),
// sdMISO (card->host). All MSB first.
interface sd_spi_target_if;
  logic sdCS;
  logic sdSCLK;
  logic sdMOSI;
  logic sdMISO;

  modport master (output sdCS, output sdSCLK, output sdMOSI, input sdMISO);
  modport slave  (input sdCS, input sdSCLK, input sdMOSI, output sdMISO);
endinterface

// File: rtl/sd_spi_target.sv
// sd_spi_target: SPI-mode SD card responder backed by a byte-wide memory.
// Ports:
//   clk, resetn     system clock (>= 8x sdSCLK), async active-low reset
//   spi             slave modport: sdCS, sdSCLK, sdMOSI in; sdMISO out
//   mem_addr        {block[BLK_W-1:0], offset[8:0]}
//   mem_rdata       read data, valid one clk after mem_addr
//   mem_wdata/we    write data and one-clk write strobe
//   card_idle       R1 idle bit
//   busy            high during read token/data/CRC and the whole write phase
module sd_spi_target #(
  parameter int unsigned BLK_W       = 7,
  parameter int unsigned ACMD41_BUSY = 1,
  parameter int unsigned READ_GAP    = 1,
  parameter int unsigned BUSY_BYTES  = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  sd_spi_target_if.slave       spi,
  output logic [BLK_W+8:0]     mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  output logic                 card_idle,
  output logic                 busy
);

  typedef enum logic [2:0] {
    CMD_WAIT, CMD_ARGS, RESP, RD, WR_TOK, WR_DATA, WR_CRC, WR_RESP
  } state_t;

  // Bytes clocked out in RD: gap, token, 512 data, 2 CRC.
  localparam int unsigned RD_LAST = READ_GAP + 515;

  logic [2:0]       r_sclk_s;
  logic [1:0]       r_mosi_s, r_cs_s;
  logic             w_rise, w_fall, w_cs_hi, w_byte_done;
  logic [2:0]       r_bitcnt;
  logic [6:0]       r_rx, r_tx;
  logic [7:0]       w_rx_byte, w_load_byte;
  logic             r_miso, r_load, r_txmem;
  logic [7:0]       r_txnext;

  state_t           r_state, w_state_n, r_post, w_post_n;
  logic [5:0]       r_cmd, w_cmd_n;
  logic [31:0]      r_arg, w_arg_n;
  logic [9:0]       r_cnt, w_cnt_n;
  logic [39:0]      r_resp, w_resp_n;
  logic [2:0]       r_rlen, w_rlen_n;
  logic [BLK_W-1:0] r_blk, w_blk_n;
  logic             r_idle, w_idle_n, r_app, w_app_n;
  logic [7:0]       r_acnt, w_acnt_n;
  logic [7:0]       r_wdata, w_wdata_n;
  logic             r_we, w_we_n;
  logic             w_off_clr, w_off_inc;
  logic [7:0]       w_txnext_n;
  logic             w_txmem_n;
  logic [8:0]       r_off;

  assign w_rise      = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_fall      = ~r_sclk_s[1] & r_sclk_s[2];
  assign w_cs_hi     = r_cs_s[1];
  assign w_rx_byte   = {r_rx, r_mosi_s[1]};
  assign w_byte_done = w_rise && (r_bitcnt == 3'd7) && !w_cs_hi;
  assign w_load_byte = r_txmem ? mem_rdata : r_txnext;

  assign spi.sdMISO = r_miso;
  assign mem_addr   = {r_blk, r_off};
  assign mem_wdata  = r_wdata;
  assign mem_we     = r_we;
  assign card_idle  = r_idle;
  assign busy       = ((r_state == RD) && (32'(r_cnt) > READ_GAP)) ||
                      (r_state inside {WR_TOK, WR_DATA, WR_CRC, WR_RESP});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sclk_s <= '0;
      r_mosi_s <= '0;
      r_cs_s   <= '1;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], spi.sdSCLK};
      r_mosi_s <= {r_mosi_s[0], spi.sdMOSI};
      r_cs_s   <= {r_cs_s[0], spi.sdCS};
    end
  end

  // Bit level: sample on rise, shift out on fall. The byte chosen at the 8th
  // rise is held in r_txnext (or fetched from memory) and loaded on the next fall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bitcnt <= '0;
      r_rx     <= '0;
      r_tx     <= '1;
      r_miso   <= 1'b1;
      r_load   <= 1'b0;
      r_txnext <= '1;
      r_txmem  <= 1'b0;
    end else if (w_cs_hi) begin
      r_bitcnt <= '0;
      r_tx     <= '1;
      r_miso   <= 1'b1;
      r_load   <= 1'b0;
    end else begin
      if (w_rise) begin
        r_rx     <= w_rx_byte[6:0];
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          r_load   <= 1'b1;
          r_txnext <= w_txnext_n;
          r_txmem  <= w_txmem_n;
        end
      end
      if (w_fall) begin
        if (r_load) begin
          r_load <= 1'b0;
          r_miso <= w_load_byte[7];
          r_tx   <= w_load_byte[6:0];
        end else begin
          r_miso <= r_tx[6];
          r_tx   <= {r_tx[5:0], 1'b1};
        end
      end
    end
  end

  // Offset advances after each memory read load or write strobe, saturating at 511.
  assign w_off_inc = r_we | (w_fall & r_load & r_txmem & ~w_cs_hi);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          r_off <= '0;
    else if (w_off_clr)                   r_off <= '0;
    else if (w_off_inc && r_off != '1)    r_off <= r_off + 9'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= CMD_WAIT;
      r_post  <= CMD_WAIT;
      r_cmd   <= '0;
      r_arg   <= '0;
      r_cnt   <= '0;
      r_resp  <= '0;
      r_rlen  <= '0;
      r_blk   <= '0;
      r_idle  <= 1'b1;
      r_app   <= 1'b0;
      r_acnt  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_post  <= w_post_n;
      r_cmd   <= w_cmd_n;
      r_arg   <= w_arg_n;
      r_cnt   <= w_cnt_n;
      r_resp  <= w_resp_n;
      r_rlen  <= w_rlen_n;
      r_blk   <= w_blk_n;
      r_idle  <= w_idle_n;
      r_app   <= w_app_n;
      r_acnt  <= w_acnt_n;
      r_wdata <= w_wdata_n;
      r_we    <= w_we_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_post_n   = r_post;
    w_cmd_n    = r_cmd;
    w_arg_n    = r_arg;
    w_cnt_n    = r_cnt;
    w_resp_n   = r_resp;
    w_rlen_n   = r_rlen;
    w_blk_n    = r_blk;
    w_idle_n   = r_idle;
    w_app_n    = r_app;
    w_acnt_n   = r_acnt;
    w_wdata_n  = r_wdata;
    w_we_n     = 1'b0;
    w_off_clr  = 1'b0;
    w_txnext_n = 8'hFF;
    w_txmem_n  = 1'b0;
    if (w_cs_hi) begin
      w_state_n = CMD_WAIT;
    end else if (w_byte_done) begin
      unique case (r_state)
        CMD_WAIT: if (w_rx_byte[7:6] == 2'b01) begin
          w_cmd_n   = w_rx_byte[5:0];
          w_cnt_n   = '0;
          w_state_n = CMD_ARGS;
        end
        CMD_ARGS: begin
          w_cnt_n = r_cnt + 10'd1;
          if (r_cnt < 10'd4) begin
            w_arg_n = 32'({r_arg, w_rx_byte});
          end else begin
            // CRC byte: decode now so the Ncr byte goes out next, then the response.
            w_state_n = RESP;
            w_post_n  = CMD_WAIT;
            w_rlen_n  = 3'd1;
            w_app_n   = 1'b0;
            w_resp_n  = {7'b0, r_idle, 32'h0};
            case (r_cmd)
              6'd0: begin
                w_resp_n = {8'h01, 32'h0};
                w_idle_n = 1'b1;
                w_acnt_n = '0;
              end
              6'd8: begin
                w_resp_n = {8'h01, 8'h00, 8'h00, 8'h01, r_arg[7:0]};
                w_rlen_n = 3'd5;
              end
              6'd55: w_app_n = 1'b1;
              6'd41: begin
                if (!r_app) begin
                  w_resp_n = {5'b0, 1'b1, 1'b0, r_idle, 32'h0};
                end else if (32'(r_acnt) < ACMD41_BUSY) begin
                  w_resp_n = {8'h01, 32'h0};
                  w_acnt_n = r_acnt + 8'd1;
                end else begin
                  w_resp_n = {8'h00, 32'h0};
                  w_idle_n = 1'b0;
                end
              end
              6'd58: begin
                w_resp_n = {7'b0, r_idle, 32'hC0FF_8000};
                w_rlen_n = 3'd5;
              end
              6'd17, 6'd24: begin
                w_resp_n = {8'h00, 32'h0};
                w_blk_n  = r_arg[BLK_W-1:0];
                w_post_n = (r_cmd == 6'd17) ? RD : WR_TOK;
              end
              default: w_resp_n = {5'b0, 1'b1, 1'b0, r_idle, 32'h0};
            endcase
          end
        end
        RESP: begin
          if (r_rlen != 3'd0) begin
            w_txnext_n = r_resp[39:32];
            w_resp_n   = {r_resp[31:0], 8'h00};
            w_rlen_n   = r_rlen - 3'd1;
          end else begin
            w_state_n = r_post;
            w_cnt_n   = '0;
            w_off_clr = 1'b1;
            if (r_post == RD) begin
              w_cnt_n    = 10'd1;
              w_txnext_n = (READ_GAP == 0) ? 8'hFE : 8'hFF;
            end
          end
        end
        RD: begin
          // r_cnt is the index of the byte being chosen now.
          if (32'(r_cnt) == RD_LAST) begin
            w_state_n = CMD_WAIT;
          end else begin
            w_cnt_n = r_cnt + 10'd1;
            if (32'(r_cnt) == READ_GAP)
              w_txnext_n = 8'hFE;
            else if (32'(r_cnt) > READ_GAP && 32'(r_cnt) < READ_GAP + 513)
              w_txmem_n = 1'b1;
          end
        end
        WR_TOK: if (w_rx_byte == 8'hFE) begin
          w_state_n = WR_DATA;
          w_cnt_n   = '0;
          w_off_clr = 1'b1;
        end
        WR_DATA: begin
          w_we_n    = 1'b1;
          w_wdata_n = w_rx_byte;
          if (r_cnt == 10'd511) begin
            w_state_n = WR_CRC;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 10'd1;
          end
        end
        WR_CRC: begin
          if (r_cnt == 10'd1) begin
            w_txnext_n = 8'h05;
            w_state_n  = WR_RESP;
            w_cnt_n    = '0;
          end else begin
            w_cnt_n = r_cnt + 10'd1;
          end
        end
        WR_RESP: begin
          if (32'(r_cnt) < BUSY_BYTES) begin
            w_txnext_n = 8'h00;
            w_cnt_n    = r_cnt + 10'd1;
          end else begin
            w_state_n = CMD_WAIT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_target.sv
module tb_sd_spi_target;
  localparam int unsigned BLK_W = 7;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  sd_spi_target_if spi();
  logic [BLK_W+8:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem_wdata;
  logic mem_we, card_idle, busy;

  sd_spi_target #(.BLK_W(BLK_W), .ACMD41_BUSY(1), .READ_GAP(1), .BUSY_BYTES(4)) dut (
    .clk(clk), .resetn(resetn), .spi(spi.slave),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .card_idle(card_idle), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: preloaded with addr[7:0]^3, registered read, counted writes.
  logic [7:0] mem [0:65535];
  logic mem_ready = 1'b0;
  int unsigned we_cnt = 0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'(i) ^ 8'h03;
      mem_ready <= 1'b1;
    end else begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        we_cnt <= we_cnt + 1;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic mid_busy;
  logic [BLK_W+8:0] mid_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: rebuilds MISO bytes on sdSCLK rises and checks them against the queue.
  initial begin : monitor
    int mbits;
    int midx;
    logic [7:0] mbyte;
    logic [7:0] e;
    mbits = 0;
    midx = 0;
    mbyte = 8'h00;
    forever begin
      @(posedge spi.sdSCLK or posedge spi.sdCS);
      if (spi.sdCS) begin
        mbits = 0;
      end else begin
        mbyte = {mbyte[6:0], spi.sdMISO};
        mbits++;
        if (mbits == 8) begin
          mbits = 0;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL miso_byte[%0d]: got %02h expected none queued", midx, mbyte);
          end else begin
            e = exp_q.pop_front();
            if (mbyte !== e) begin
              n_err++;
              $display("FAIL miso_byte[%0d]: got %02h expected %02h", midx, mbyte, e);
            end
          end
          midx++;
        end
      end
    end
  end

  task automatic half();
    repeat (8) @(posedge clk);
    #2;
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] ex);
    exp_q.push_back(ex);
    for (int i = 7; i >= 0; i--) begin
      spi.sdMOSI = tx[i];
      half();
      spi.sdSCLK = 1'b1;
      if (i == 3) begin
        mid_busy = busy;
        mid_addr = mem_addr;
      end
      half();
      spi.sdSCLK = 1'b0;
    end
  endtask

  // Sends a 6-byte frame, the Ncr byte, and n response bytes (left-aligned in r).
  task automatic cmd(input logic [7:0] c, input logic [31:0] a, input logic [7:0] crc,
                     input logic [39:0] r, input int n);
    logic [39:0] rr;
    xfer(c, 8'hFF);
    for (int i = 3; i >= 0; i--) xfer(a[8*i +: 8], 8'hFF);
    xfer(crc, 8'hFF);
    xfer(8'hFF, 8'hFF);
    rr = r;
    for (int i = 0; i < n; i++) begin
      xfer(8'hFF, rr[39:32]);
      rr = rr << 8;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"}, 32'(spi.sdMISO), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_idle"}, 32'(card_idle), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin : stim
    int bad;
    int unsigned w0;
    spi.sdCS = 1'b1;
    spi.sdSCLK = 1'b0;
    spi.sdMOSI = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk_reset_vals("rst");
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    spi.sdCS = 1'b0;
    half();

    // Initialisation sequence
    cmd(8'h40, 32'h0, 8'h95, {8'h01, 32'h0}, 1);
    xfer(8'hFF, 8'hFF);
    chk("idle_cmd0", 32'(card_idle), 32'd1);
    cmd(8'h48, 32'h0000_01AA, 8'h87, 40'h01_0000_01AA, 5);
    cmd(8'h77, 32'h0, 8'hFF, {8'h01, 32'h0}, 1);
    cmd(8'h69, 32'h4000_0000, 8'hFF, {8'h01, 32'h0}, 1);
    chk("idle_acmd41_busy", 32'(card_idle), 32'd1);
    cmd(8'h77, 32'h0, 8'hFF, {8'h01, 32'h0}, 1);
    cmd(8'h69, 32'h4000_0000, 8'hFF, {8'h00, 32'h0}, 1);
    chk("idle_acmd41_ready", 32'(card_idle), 32'd0);
    cmd(8'h7A, 32'h0, 8'hFF, 40'h00_C0FF_8000, 5);
    cmd(8'h49, 32'h0, 8'hFF, {8'h04, 32'h0}, 1);

    // Single-block read of block 3
    cmd(8'h51, 32'd3, 8'hFF, {8'h00, 32'h0}, 1);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFE);
    chk("rd_busy_token", 32'(mid_busy), 32'd1);
    chk("rd_addr_token", 32'(mid_addr), 32'h600);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      xfer(8'hFF, 8'(i) ^ 8'h03);
      if (mid_busy !== 1'b1) bad++;
    end
    chk("rd_busy_data", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      xfer(8'hFF, 8'hFF);
      if (mid_busy !== 1'b1) bad++;
    end
    chk("rd_busy_crc", 32'(bad), 32'd0);
    xfer(8'hFF, 8'hFF);
    chk("rd_busy_after", 32'(mid_busy), 32'd0);

    // Single-block write of block 5
    w0 = we_cnt;
    cmd(8'h58, 32'd5, 8'hFF, {8'h00, 32'h0}, 1);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFE, 8'hFF);
    for (int i = 0; i < 512; i++) xfer(8'(i), 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h05);
    for (int i = 0; i < 4; i++) xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'hFF);
    chk("wr_we_count", we_cnt - w0, 32'd512);
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[16'hA00 + 16'(i)] !== 8'(i)) bad++;
    chk("wr_mem_pattern", 32'(bad), 32'd0);
    chk("wr_mem_below", 32'(mem[16'h9FF]), 32'hFC);
    chk("wr_mem_above", 32'(mem[16'hC00]), 32'h03);

    // Deselect mid-read
    cmd(8'h51, 32'd3, 8'hFF, {8'h00, 32'h0}, 1);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFE);
    for (int i = 0; i < 100; i++) xfer(8'hFF, 8'(i) ^ 8'h03);
    half();
    chk("abort_miso_before", 32'(spi.sdMISO), 32'd0);
    chk("abort_busy_before", 32'(busy), 32'd1);
    spi.sdCS = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_miso", 32'(spi.sdMISO), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    half();
    spi.sdCS = 1'b0;
    half();
    cmd(8'h40, 32'h0, 8'h95, {8'h01, 32'h0}, 1);
    xfer(8'hFF, 8'hFF);

    // ACMD41 count restarts after CMD0
    cmd(8'h77, 32'h0, 8'hFF, {8'h01, 32'h0}, 1);
    cmd(8'h69, 32'h4000_0000, 8'hFF, {8'h01, 32'h0}, 1);
    cmd(8'h77, 32'h0, 8'hFF, {8'h01, 32'h0}, 1);
    cmd(8'h69, 32'h4000_0000, 8'hFF, {8'h00, 32'h0}, 1);
    chk("idle_after_reinit", 32'(card_idle), 32'd0);

    // Reset mid-write
    cmd(8'h58, 32'd5, 8'hFF, {8'h00, 32'h0}, 1);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFE, 8'hFF);
    for (int i = 0; i < 10; i++) xfer(8'hA0 + 8'(i), 8'hFF);
    half();
    chk("midwr_busy", 32'(busy), 32'd1);
    chk("midwr_wdata", 32'(mem_wdata), 32'hA9);
    resetn = 1'b0;
    #1;
    chk_reset_vals("midwr_rst");
    spi.sdCS = 1'b1;
    half();
    resetn = 1'b1;
    half();

    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d bytes outstanding expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
